mb_access_arbiter: RTL and testbench
====================================

Name: mb_access_arbiter

Overview:
- Single-clock front end that shares a multi-bank dual-port memory (one write port and one read port per bank) between num_requesters request/response channels.
- Decodes each flat address into bank and entry, arbitrates per bank and per port with round-robin, and drives the per-bank memory command arrays.
- Steers read data back to the requester that issued the read, in order, with fixed latency.
- Sits between client engines and the banked memory instance.

Parameters:
- num_requesters, 4, number of request/response channels.
- num_banks, 4, number of memory banks; power of two.
- num_bank_entries, 64, entries per bank; power of two.
- data_bit_width, 32, data width.
- Derived: bank_bits=$clog2(num_banks); entry_bits=$clog2(num_bank_entries); addr_bits=bank_bits+entry_bits; req_bits=$clog2(num_requesters).

Ports:
- clk  in  1  single clock; also drives the memory's wr_clk and rd_clk.
- rst_n  in  1  reset, synchronous, active-low.
- req_valid  in  [num_requesters]  request valid.
- req_write  in  [num_requesters]  1=write, 0=read.
- req_addr  in  addr_bits x num_requesters  flat address; bank=addr[bank_bits-1:0], entry=addr[addr_bits-1:bank_bits].
- req_wdata  in  data_bit_width x num_requesters  write data.
- req_ready  out  [num_requesters]  request accepted this cycle.
- rsp_valid  out  [num_requesters]  read response valid (one-cycle pulse).
- rsp_rdata  out  data_bit_width x num_requesters  read data.
- mem_wr_en  out  [num_banks]  per-bank write enable.
- mem_wr_addr  out  entry_bits x num_banks  per-bank write entry.
- mem_wr_data  out  data_bit_width x num_banks  per-bank write data.
- mem_rd_en  out  [num_banks]  per-bank read enable.
- mem_rd_addr  out  entry_bits x num_banks  per-bank read entry.
- mem_rd_data  in  data_bit_width x num_banks  registered read data, valid 1 cycle after mem_rd_en.
- stall_count  out  16  saturating count of cycles in which any valid request was not ready.

Behaviour:
- Reset (rst_n=0 at a clk edge):
  - All mem_* enables, addresses and data, rsp_valid, rsp_rdata, stall_count and all pipeline/tag registers clear to 0.
  - All round-robin pointers go to 0.
  - req_ready is forced to 0 while rst_n=0.
  - Reset mid-operation discards in-flight reads; no rsp_valid is produced for them.
- Arbitration:
  - Combinational, in the same cycle as the request.
  - Each bank holds independent write and read arbiters: wr_ptr[b] and rd_ptr[b], each req_bits wide.
  - Requesters with req_valid=1, a matching bank and a matching req_write compete for that bank/port.
  - The winner is the first requester at or after the pointer, searching upward with wrap.
  - req_ready[i]=1 only when requester i wins. Acceptance is req_valid & req_ready.
  - After a grant, the pointer becomes (winner+1) mod num_requesters. With no grant the pointer holds.
  - req_ready may be 1 while req_valid=0 is never possible: ready is 0 without valid.
- Bandwidth and fairness:
  - Per bank, at most one write and one read are accepted per cycle.
  - Different banks proceed in parallel, so up to num_banks writes plus num_banks reads per cycle.
  - A continuously valid requester waits at most num_requesters-1 cycles for its bank/port.
- Command pipeline:
  - A request accepted in cycle T drives registered mem_wr_* or mem_rd_* in cycle T+1.
  - Unused banks have their enable at 0; their address and data hold the previous value.
- Read return:
  - The accepted requester index for each bank is tracked with a valid bit through a tag pipeline.
  - mem_rd_data is valid in T+2. rsp_valid[i] and rsp_rdata[i] are registered and asserted in T+3, exactly one cycle.
  - Latency is fixed at 3 with no backpressure; responses per requester come back in acceptance order.
  - rsp_rdata holds its value when rsp_valid=0.
- Hazards:
  - Write and read to the same bank and entry accepted in the same cycle: the read returns the old data.
  - A read accepted at T+1 or later after a write accepted at T returns the new data.
  - Two writes to the same address can only be serialized by the same bank arbiter, so the later-accepted write wins.
- stall_count:
  - Increments by 1 on each cycle where any req_valid[i]&~req_ready[i] is set.
  - Saturates at 16'hFFFF and is cleared only by reset.

Test Plan:
- Reset: hold rst_n=0 with all req_valid=1 for 3 cycles -> req_ready=0, all mem enables=0, rsp_valid=0, stall_count=0.
- Write then read: req0 writes addr 0x05 (bank 1, entry 1), data 0xDEADBEEF, at T=10; req0 reads 0x05 at T=11 -> mem_wr_en[1]=1 at T=11, mem_rd_en[1]=1 at T=12, rsp_valid[0]=1 with 0xDEADBEEF at T=14.
- Bank conflict: req0–req3 all read bank 2 continuously from pointer 0 -> grants 0,1,2,3,0 on consecutive cycles; stall_count increments 1 per cycle.
- Parallel banks: req0–req3 read banks 0–3 in the same cycle -> all req_ready=1, four mem_rd_en set, four rsp_valid set together 3 cycles later.
- Same-cycle hazard: req0 writes 0x11 to addr 0x08 while req1 reads 0x08 (prior value 0x22) -> rsp_rdata[1]=0x22; a later read returns 0x11.
- Saturation and mid-flight reset: preload stall_count near 0xFFFF via sustained conflict -> holds at 0xFFFF; assert rst_n=0 one cycle after a read is accepted -> no rsp_valid follows.

Source files
------------

// File: rtl/mb_access_arbiter.sv
// Round-robin front end sharing a banked dual-port memory between request channels.
// Each bank has independent write/read arbiters; read data returns with a fixed 3-cycle latency.
module mb_access_arbiter #(
   parameter int num_requesters   = 4,
   parameter int num_banks        = 4,
   parameter int num_bank_entries = 64,
   parameter int data_bit_width   = 32,
   localparam int bank_bits  = $clog2(num_banks),
   localparam int entry_bits = $clog2(num_bank_entries),
   localparam int addr_bits  = bank_bits + entry_bits,
   localparam int req_bits   = (num_requesters > 1) ? $clog2(num_requesters) : 1
) (
   input  logic                                          clk_i,
   input  logic                                          rst_n_i,
   input  logic [num_requesters-1:0]                     req_valid_i,
   input  logic [num_requesters-1:0]                     req_write_i,
   input  logic [num_requesters-1:0][addr_bits-1:0]      req_addr_i,
   input  logic [num_requesters-1:0][data_bit_width-1:0] req_wdata_i,
   output logic [num_requesters-1:0]                     req_ready_o,
   output logic [num_requesters-1:0]                     rsp_valid_o,
   output logic [num_requesters-1:0][data_bit_width-1:0] rsp_rdata_o,
   output logic [num_banks-1:0]                          mem_wr_en_o,
   output logic [num_banks-1:0][entry_bits-1:0]          mem_wr_addr_o,
   output logic [num_banks-1:0][data_bit_width-1:0]      mem_wr_data_o,
   output logic [num_banks-1:0]                          mem_rd_en_o,
   output logic [num_banks-1:0][entry_bits-1:0]          mem_rd_addr_o,
   input  logic [num_banks-1:0][data_bit_width-1:0]      mem_rd_data_i,
   output logic [15:0]                                   stall_count_o
);

   logic [num_banks-1:0][req_bits-1:0]          wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
   logic [num_banks-1:0][num_requesters-1:0]    wr_cand, rd_cand;
   logic [num_banks-1:0]                        wr_gnt, rd_gnt;
   logic [num_banks-1:0][req_bits-1:0]          wr_win, rd_win;
   logic [num_requesters-1:0]                   ready;
   logic                                        any_stall;

   logic [num_banks-1:0]                        mem_wr_en_q, mem_rd_en_q;
   logic [num_banks-1:0][entry_bits-1:0]        mem_wr_addr_q, mem_rd_addr_q;
   logic [num_banks-1:0][data_bit_width-1:0]    mem_wr_data_q;
   logic [num_banks-1:0]                        tag1_vld_q, tag2_vld_q;
   logic [num_banks-1:0][req_bits-1:0]          tag1_idx_q, tag2_idx_q;
   logic [num_requesters-1:0]                   rsp_valid_q, rsp_valid_d;
   logic [num_requesters-1:0][data_bit_width-1:0] rsp_rdata_q, rsp_rdata_d;
   logic [15:0]                                 stall_q;

   function automatic int wrap_idx(input logic [req_bits-1:0] p, input int k);
      int s;
      s = int'(p) + k;
      return (s >= num_requesters) ? s - num_requesters : s;
   endfunction

   always_comb begin
      wr_cand = '0;
      rd_cand = '0;
      for (int b = 0; b < num_banks; b++) begin
         for (int i = 0; i < num_requesters; i++) begin
            if (req_valid_i[i] && (req_addr_i[i][bank_bits-1:0] == bank_bits'(b))) begin
               wr_cand[b][i] = req_write_i[i];
               rd_cand[b][i] = ~req_write_i[i];
            end
         end
      end
   end

   // Scan downward from the farthest offset so the nearest candidate at/after the pointer wins.
   always_comb begin
      wr_gnt   = '0;
      rd_gnt   = '0;
      wr_win   = '0;
      rd_win   = '0;
      ready    = '0;
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      for (int b = 0; b < num_banks; b++) begin
         for (int k = num_requesters - 1; k >= 0; k--) begin
            if (wr_cand[b][wrap_idx(wr_ptr_q[b], k)]) begin
               wr_gnt[b] = 1'b1;
               wr_win[b] = req_bits'(wrap_idx(wr_ptr_q[b], k));
            end
            if (rd_cand[b][wrap_idx(rd_ptr_q[b], k)]) begin
               rd_gnt[b] = 1'b1;
               rd_win[b] = req_bits'(wrap_idx(rd_ptr_q[b], k));
            end
         end
         if (wr_gnt[b]) begin
            ready[wr_win[b]] = 1'b1;
            wr_ptr_d[b]      = req_bits'(wrap_idx(wr_win[b], 1));
         end
         if (rd_gnt[b]) begin
            ready[rd_win[b]] = 1'b1;
            rd_ptr_d[b]      = req_bits'(wrap_idx(rd_win[b], 1));
         end
      end
   end

   assign req_ready_o = rst_n_i ? ready : '0;
   assign any_stall   = |(req_valid_i & ~req_ready_o);

   // A requester issues at most one read per cycle, so at most one bank returns to it at a time.
   always_comb begin
      rsp_valid_d = '0;
      rsp_rdata_d = rsp_rdata_q;
      for (int b = 0; b < num_banks; b++) begin
         if (tag2_vld_q[b]) begin
            rsp_valid_d[tag2_idx_q[b]] = 1'b1;
            rsp_rdata_d[tag2_idx_q[b]] = mem_rd_data_i[b];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!rst_n_i) begin
         wr_ptr_q      <= '0;
         rd_ptr_q      <= '0;
         mem_wr_en_q   <= '0;
         mem_wr_addr_q <= '0;
         mem_wr_data_q <= '0;
         mem_rd_en_q   <= '0;
         mem_rd_addr_q <= '0;
         tag1_vld_q    <= '0;
         tag1_idx_q    <= '0;
         tag2_vld_q    <= '0;
         tag2_idx_q    <= '0;
         rsp_valid_q   <= '0;
         rsp_rdata_q   <= '0;
         stall_q       <= '0;
      end else begin
         wr_ptr_q    <= wr_ptr_d;
         rd_ptr_q    <= rd_ptr_d;
         mem_wr_en_q <= wr_gnt;
         mem_rd_en_q <= rd_gnt;
         for (int b = 0; b < num_banks; b++) begin
            if (wr_gnt[b]) begin
               mem_wr_addr_q[b] <= req_addr_i[wr_win[b]][addr_bits-1:bank_bits];
               mem_wr_data_q[b] <= req_wdata_i[wr_win[b]];
            end
            if (rd_gnt[b]) begin
               mem_rd_addr_q[b] <= req_addr_i[rd_win[b]][addr_bits-1:bank_bits];
            end
         end
         tag1_vld_q  <= rd_gnt;
         tag1_idx_q  <= rd_win;
         tag2_vld_q  <= tag1_vld_q;
         tag2_idx_q  <= tag1_idx_q;
         rsp_valid_q <= rsp_valid_d;
         rsp_rdata_q <= rsp_rdata_d;
         if (any_stall && (stall_q != 16'hFFFF)) begin
            stall_q <= stall_q + 16'd1;
         end
      end
   end

   assign mem_wr_en_o   = mem_wr_en_q;
   assign mem_wr_addr_o = mem_wr_addr_q;
   assign mem_wr_data_o = mem_wr_data_q;
   assign mem_rd_en_o   = mem_rd_en_q;
   assign mem_rd_addr_o = mem_rd_addr_q;
   assign rsp_valid_o   = rsp_valid_q;
   assign rsp_rdata_o   = rsp_rdata_q;
   assign stall_count_o = stall_q;

endmodule

// File: tb/tb_mb_access_arbiter.sv
// Bench for mb_access_arbiter: banked memory model plus a reference arbiter and response scoreboard.
module tb_mb_access_arbiter;
   localparam int NR = 4;
   localparam int NB = 4;
   localparam int NE = 64;
   localparam int DW = 32;
   localparam int EB = 6;
   localparam int AB = 8;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic                    rst_n;
   logic [NR-1:0]           req_valid, req_write, req_ready, rsp_valid;
   logic [NR-1:0][AB-1:0]   req_addr;
   logic [NR-1:0][DW-1:0]   req_wdata, rsp_rdata;
   logic [NB-1:0]           mem_wr_en, mem_rd_en;
   logic [NB-1:0][EB-1:0]   mem_wr_addr, mem_rd_addr;
   logic [NB-1:0][DW-1:0]   mem_wr_data, mem_rd_data;
   logic [15:0]             stall_count;

   int n_cmp = 0;
   int n_err = 0;
   int cyc   = 0;

   mb_access_arbiter dut (
      .clk_i(clk), .rst_n_i(rst_n),
      .req_valid_i(req_valid), .req_write_i(req_write),
      .req_addr_i(req_addr), .req_wdata_i(req_wdata),
      .req_ready_o(req_ready), .rsp_valid_o(rsp_valid), .rsp_rdata_o(rsp_rdata),
      .mem_wr_en_o(mem_wr_en), .mem_wr_addr_o(mem_wr_addr), .mem_wr_data_o(mem_wr_data),
      .mem_rd_en_o(mem_rd_en), .mem_rd_addr_o(mem_rd_addr), .mem_rd_data_i(mem_rd_data),
      .stall_count_o(stall_count)
   );

   task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (cycle %0d)", tag, got, exp, cyc);
      end
   endtask

   function automatic logic [DW-1:0] init_word(int b, int e);
      return 32'hA500_0000 | DW'(b << 8) | DW'(e);
   endfunction

   // Banked memory: registered read, read-before-write on a same-entry collision.
   logic [DW-1:0] mem [NB][NE];
   bit mem_loaded = 1'b0;
   always @(posedge clk) begin
      if (!mem_loaded) begin
         for (int b = 0; b < NB; b++)
            for (int e = 0; e < NE; e++)
               mem[b][e] <= init_word(b, e);
         mem_loaded <= 1'b1;
      end else begin
         for (int b = 0; b < NB; b++) begin
            if (mem_rd_en[b]) mem_rd_data[b] <= mem[b][mem_rd_addr[b]];
            if (mem_wr_en[b]) mem[b][mem_wr_addr[b]] <= mem_wr_data[b];
         end
      end
   end

   typedef struct {
      int            req;
      logic [DW-1:0] data;
      int            due;
   } rsp_t;
   rsp_t sb[$];

   logic [DW-1:0] shadow [NB][NE];
   int            wr_ptr [NB];
   int            rd_ptr [NB];
   logic [NB-1:0] x_wr_en, x_rd_en;
   logic [EB-1:0] x_wr_addr [NB];
   logic [EB-1:0] x_rd_addr [NB];
   logic [DW-1:0] x_wr_data [NB];
   logic [15:0]   x_stall;

   // Reference model: checks registered outputs for this cycle, then arbitrates the current inputs.
   always @(negedge clk) begin
      logic [NR-1:0] x_ready, x_rsp;
      logic [DW-1:0] x_rdata [NR];
      logic [NB-1:0] n_wr_en, n_rd_en;
      int            win, idx, bk;
      rsp_t          r;

      if (cyc == 0) begin
         for (int b = 0; b < NB; b++) begin
            for (int e = 0; e < NE; e++) shadow[b][e] = init_word(b, e);
            wr_ptr[b] = 0; rd_ptr[b] = 0;
            x_wr_addr[b] = '0; x_rd_addr[b] = '0; x_wr_data[b] = '0;
         end
         x_wr_en = '0; x_rd_en = '0; x_stall = '0;
      end

      x_rsp = '0;
      for (int i = 0; i < NR; i++) x_rdata[i] = '0;
      while (sb.size() > 0 && sb[0].due == cyc) begin
         r = sb.pop_front();
         x_rsp[r.req]   = 1'b1;
         x_rdata[r.req] = r.data;
      end
      chk("rsp_valid", 64'(rsp_valid), 64'(x_rsp));
      for (int i = 0; i < NR; i++)
         if (x_rsp[i]) chk("rsp_rdata", 64'(rsp_rdata[i]), 64'(x_rdata[i]));
      chk("mem_wr_en", 64'(mem_wr_en), 64'(x_wr_en));
      chk("mem_rd_en", 64'(mem_rd_en), 64'(x_rd_en));
      for (int b = 0; b < NB; b++) begin
         if (x_wr_en[b]) begin
            chk("mem_wr_addr", 64'(mem_wr_addr[b]), 64'(x_wr_addr[b]));
            chk("mem_wr_data", 64'(mem_wr_data[b]), 64'(x_wr_data[b]));
         end
         if (x_rd_en[b]) chk("mem_rd_addr", 64'(mem_rd_addr[b]), 64'(x_rd_addr[b]));
      end
      chk("stall_count", 64'(stall_count), 64'(x_stall));

      x_ready = '0; n_wr_en = '0; n_rd_en = '0;
      if (rst_n) begin
         for (int b = 0; b < NB; b++) begin
            win = -1;
            for (int k = 0; k < NR; k++) begin
               idx = (rd_ptr[b] + k) % NR;
               bk  = int'(req_addr[idx][1:0]);
               if (win < 0 && req_valid[idx] && !req_write[idx] && bk == b) win = idx;
            end
            if (win >= 0) begin
               x_ready[win] = 1'b1;
               rd_ptr[b]    = (win + 1) % NR;
               n_rd_en[b]   = 1'b1;
               x_rd_addr[b] = req_addr[win][AB-1:2];
               r.req = win; r.data = shadow[b][req_addr[win][AB-1:2]]; r.due = cyc + 3;
               sb.push_back(r);
            end
         end
         for (int b = 0; b < NB; b++) begin
            win = -1;
            for (int k = 0; k < NR; k++) begin
               idx = (wr_ptr[b] + k) % NR;
               bk  = int'(req_addr[idx][1:0]);
               if (win < 0 && req_valid[idx] && req_write[idx] && bk == b) win = idx;
            end
            if (win >= 0) begin
               x_ready[win] = 1'b1;
               wr_ptr[b]    = (win + 1) % NR;
               n_wr_en[b]   = 1'b1;
               x_wr_addr[b] = req_addr[win][AB-1:2];
               x_wr_data[b] = req_wdata[win];
               shadow[b][req_addr[win][AB-1:2]] = req_wdata[win];
            end
         end
      end
      chk("req_ready", 64'(req_ready), 64'(x_ready));

      if (!rst_n) begin
         for (int b = 0; b < NB; b++) begin wr_ptr[b] = 0; rd_ptr[b] = 0; end
         sb.delete();
         x_wr_en = '0; x_rd_en = '0; x_stall = '0;
      end else begin
         x_wr_en = n_wr_en;
         x_rd_en = n_rd_en;
         if ((|(req_valid & ~x_ready)) && x_stall != 16'hFFFF) x_stall = x_stall + 16'd1;
      end
      cyc++;
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic idle();
      req_valid = '0; req_write = '0;
   endtask

   initial begin
      rst_n = 1'b0;
      req_valid = '1; req_write = '0; req_wdata = '0;
      req_addr = {8'h0C, 8'h08, 8'h04, 8'h00};
      tick(3);
      rst_n = 1'b1; idle();
      tick(3);

      // write 0xDEADBEEF to 0x05, then read it back on the next cycle
      req_valid = 4'b0001; req_write = 4'b0001;
      req_addr[0] = 8'h05; req_wdata[0] = 32'hDEADBEEF;
      tick(1);
      req_write = 4'b0000;
      tick(1);
      idle(); tick(5);

      // all four requesters read bank 2 continuously
      req_valid = '1; req_write = '0;
      req_addr = {8'h0E, 8'h0A, 8'h06, 8'h02};
      tick(5);
      idle(); tick(5);

      // one read per bank in the same cycle
      req_valid = '1; req_write = '0;
      req_addr = {8'h03, 8'h02, 8'h01, 8'h00};
      tick(1);
      idle(); tick(5);

      // same-cycle write/read collision on 0x08
      req_valid = 4'b0001; req_write = 4'b0001;
      req_addr[0] = 8'h08; req_wdata[0] = 32'h22;
      tick(1);
      idle(); tick(2);
      req_valid = 4'b0011; req_write = 4'b0001;
      req_addr[0] = 8'h08; req_wdata[0] = 32'h11; req_addr[1] = 8'h08;
      tick(1);
      idle(); tick(1);
      req_valid = 4'b0010; req_write = 4'b0000; req_addr[1] = 8'h08;
      tick(1);
      idle(); tick(5);

      // random traffic over a small address window so hazards and conflicts occur
      for (int n = 0; n < 400; n++) begin
         req_valid = 4'($urandom);
         req_write = 4'($urandom);
         for (int i = 0; i < NR; i++) begin
            req_addr[i]  = 8'($urandom_range(0, 15));
            req_wdata[i] = $urandom;
         end
         tick(1);
      end
      idle(); tick(5);

      // sustained conflict long enough to saturate stall_count
      req_valid = '1; req_write = '0;
      req_addr = {8'h0F, 8'h0B, 8'h07, 8'h03};
      tick(65600);
      idle(); tick(3);

      // reset one cycle after a read is accepted: its response must never appear
      req_valid = 4'b0001; req_write = '0; req_addr[0] = 8'h01;
      tick(1);
      idle(); rst_n = 1'b0;
      tick(2);
      rst_n = 1'b1;
      tick(6);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
